// File: rtl/hazard_free_flag_gen.sv
// Multi-channel hazard-free flag generator.
// Each channel registers its enable and data inputs and filters out short pulses.
// It then detects a level or an edge event, as chosen by the channel mode.
// Every flag and flag_any leave the block straight from flip-flops.
module hazard_free_flag_gen #(
    parameter int unsigned CH         = 4,
    parameter int unsigned STABLE_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   din,
    input  logic [2*CH-1:0] mode,
    input  logic            sticky,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   flag,
    output logic            flag_any
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;

    // Input capture stage
    logic [CH-1:0]            s_din;
    logic [CH-1:0]            s_en;

    // Filter state: accepted value, stability counter, one-cycle update strobe
    logic [CH-1:0]            f;
    logic [CH-1:0][CNT_W-1:0] cnt;
    logic [CH-1:0]            upd;
    logic [CH-1:0]            upd_rise;

    logic [CH-1:0]            f_nxt;
    logic [CH-1:0][CNT_W-1:0] cnt_nxt;
    logic [CH-1:0]            upd_nxt;
    logic [CH-1:0]            upd_rise_nxt;

    logic [CH-1:0]            ev;
    logic [CH-1:0]            flag_nxt;

    // Stability filter: accept s_din only after it differs from f for STABLE_CYC samples
    always_comb begin
        f_nxt        = f;
        cnt_nxt      = cnt;
        upd_nxt      = '0;
        upd_rise_nxt = '0;
        for (int c = 0; c < int'(CH); c++) begin
            if (s_din[c] == f[c]) begin
                cnt_nxt[c] = '0;
            end else if (cnt[c] == CNT_LAST) begin
                f_nxt[c]        = s_din[c];
                cnt_nxt[c]      = '0;
                upd_nxt[c]      = 1'b1;
                upd_rise_nxt[c] = s_din[c];
            end else begin
                cnt_nxt[c] = cnt[c] + CNT_W'(1);
            end
        end
    end

    // Event select per channel mode, evaluated on the registered filter outputs
    always_comb begin
        ev = '0;
        for (int c = 0; c < int'(CH); c++) begin
            case (mode[2*c +: 2])
                MODE_LEVEL: ev[c] = f[c];
                MODE_RISE:  ev[c] = upd[c] & upd_rise[c];
                MODE_FALL:  ev[c] = upd[c] & ~upd_rise[c];
                default:    ev[c] = upd[c];
            endcase
        end
    end

    // Flag next state: a set wins over a simultaneous clear; clear only matters when sticky
    always_comb begin
        flag_nxt = ev & s_en;
        if (sticky) begin
            flag_nxt = (flag & ~clr) | (ev & s_en);
        end
    end

    // All state registers; reset beats every set
    always_ff @(posedge clk) begin
        if (rst) begin
            s_din    <= '0;
            s_en     <= '0;
            f        <= '0;
            cnt      <= '0;
            upd      <= '0;
            upd_rise <= '0;
            flag     <= '0;
            flag_any <= 1'b0;
        end else begin
            s_din    <= din;
            s_en     <= en;
            f        <= f_nxt;
            cnt      <= cnt_nxt;
            upd      <= upd_nxt;
            upd_rise <= upd_rise_nxt;
            flag     <= flag_nxt;
            flag_any <= |flag_nxt;
        end
    end

endmodule

// File: doc/hazard_free_flag_gen.md
# hazard_free_flag_gen

Parametrised, multi-channel, hazard-free flag generator; next generation of the single-channel enable/data flag block. Each channel registers its enable and data inputs, rejects pulses shorter than a programmable stability window, detects level or edge events per channel mode, and drives fully registered flags, optionally sticky. Sits between asynchronous-ish or glitchy control inputs and downstream logic that must never see a combinational race on a flag.

## Interface
- CH, 4, number of independent channels (>=1)
- STABLE_CYC, 3, cycles a new input value must persist before acceptance (>=1)
- CNT_W, derived = clog2(STABLE_CYC+1), stability counter width (localparam)

- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  CH  per-channel enable; flags only set while enabled
- din  input  CH  per-channel data
- mode  input  2*CH  per channel [2c+1:2c]: 00 level-high, 01 rising edge, 10 falling edge, 11 either edge
- sticky  input  1  1: flags hold until cleared; 0: flags follow events
- clr  input  CH  per-channel sticky-flag clear
- flag  output  CH  registered per-channel flag
- flag_any  output  1  registered OR of next-state flag vector

## Operation
- Stage 1 (per channel): s_din <= din, s_en <= en every cycle; no output depends combinationally on any input.
- Filter: state f (accepted value), counter cnt.
  - s_din == f: cnt <= 0.
  - s_din != f and cnt < STABLE_CYC-1: cnt <= cnt+1.
  - s_din != f and cnt == STABLE_CYC-1: f <= s_din, cnt <= 0; asserts one-cycle internal upd with direction.
  - Value returning to f before acceptance resets cnt; pulse shorter than STABLE_CYC sampled cycles is discarded.
- Event ev per mode: 00 ev = f (after update); 01 ev = upd & rise; 10 ev = upd & fall; 11 ev = upd.
- Flag next state nf:
  - sticky=0: nf = ev & s_en.
  - sticky=1: nf = (flag & ~clr) | (ev & s_en); set wins over simultaneous clr.
  - clr ignored when sticky=0.
- flag <= nf; flag_any <= |nf (same cycle as flag, glitch-free).
- mode/sticky changes: take effect at next edge; filter state and cnt untouched. Switching sticky 1->0 drops held flags next cycle unless ev present.
- en deasserted: filter keeps tracking din; no new sets; sticky flags retained.
- Channels fully independent; no shared state except flag_any.

## Timing
- Reset (rst=1 at an edge): s_din, s_en, f, cnt, flag, flag_any all 0. Reset mid-filter abandons count; reset beats every set.
- After rst release with din held 1: f=0, so a rising edge is detected once stable.
- Latency: din change captured into s_din at edge E0; f updates at edge E0+STABLE_CYC; flag asserts at edge E0+STABLE_CYC+1 (4 edges for STABLE_CYC=3).
- en path: s_en at E0, used with event evaluated at edge E0+1 or later.
- Edge modes, non-sticky: flag is exactly one cycle high per accepted transition.
- Level mode, non-sticky: flag high while f=1 and s_en=1, one-cycle lag on en.
- STABLE_CYC=1: f updates at the edge after sampling; flag 2 edges after sampling.

## Test plan
- Reset/latency: CH=4, STABLE_CYC=3, mode=all 01, en=F; after rst, din[0] 0->1 captured at E0 -> flag[0] and flag_any high only at E0+4, for one cycle; all outputs 0 during reset.
- Glitch reject: din[1] high for 2 cycles then low, mode 11 -> flag[1] never asserts; 3-cycle pulse -> two one-cycle flag pulses (rise and fall), 3 cycles apart.
- Enable race: en[2] 0->1 same cycle din[2] 1->0, mode 00 (prior f=1) -> flag[2] at most equals registered f & s_en, no single-cycle spike after f drops; with en=0 whole time flag[2] stays 0.
- Sticky: sticky=1, mode 01, rise on ch3 -> flag[3] holds; clr[3] pulse -> 0 next edge; clr coinciding with new event -> flag stays 1.
- Mode switch/reset mid-count: change mode 01->10 during count, falling edge only flagged; assert rst at cnt=2 -> cnt,f,flag cleared, no flag after release until fresh stable change.
